// File: rtl/multi_digit_counter_display.sv
// N-digit BCD up/down counter with count-tick divider, load, wrap detect and
// a multiplexed seven-segment scan driver sharing one segment bus.
module multi_digit_counter_display #(
   parameter int NUM_DIGITS     = 4,
   parameter int TICK_DIV       = 50_000_000,
   parameter int SCAN_DIV       = 50_000,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    En,
   input  logic                    Dir,
   input  logic                    Load,
   input  logic [4*NUM_DIGITS-1:0] LoadVal,
   output logic [4*NUM_DIGITS-1:0] Count,
   output logic                    Tick,
   output logic                    Wrap,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int DIV_W  = $clog2(TICK_DIV);
   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]        SEG_BLANK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   logic [DIV_W-1:0]        div_q, div_d;
   logic [SCAN_W-1:0]       scan_q, scan_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    all_nine, all_zero;
   logic [3:0]              digit_sel;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b1000000;
         4'd1:    p = 7'b1111001;
         4'd2:    p = 7'b0100100;
         4'd3:    p = 7'b0110000;
         4'd4:    p = 7'b0011001;
         4'd5:    p = 7'b0010010;
         4'd6:    p = 7'b0000010;
         4'd7:    p = 7'b1111000;
         4'd8:    p = 7'b0000000;
         4'd9:    p = 7'b0010000;
         default: p = 7'b1111111;
      endcase
      return (SEG_ACTIVE_LOW != 0) ? p : ~p;
   endfunction

   always_comb begin
      all_nine = 1'b1;
      all_zero = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (cnt_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
         if (cnt_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
      end
      Tick = En && (div_q == DIV_LAST);
      Wrap = Tick && !Load && (Dir ? all_zero : all_nine);
   end

   // Carry/borrow ripples through every digit in a single cycle.
   always_comb begin
      logic [3:0] nib;
      logic       carry;
      nib   = '0;
      carry = 1'b0;
      cnt_d = cnt_q;
      div_d = div_q;
      if (Load) begin
         div_d = '0;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            nib = LoadVal[4*i +: 4];
            cnt_d[4*i +: 4] = (nib > 4'd9) ? 4'd0 : nib;
         end
      end else begin
         if (En) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
         if (Tick) begin
            carry = 1'b1;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
               nib = cnt_q[4*i +: 4];
               if (carry) begin
                  if (!Dir) begin
                     if (nib == 4'd9) nib = 4'd0;
                     else begin
                        nib   = nib + 4'd1;
                        carry = 1'b0;
                     end
                  end else begin
                     if (nib == 4'd0) nib = 4'd9;
                     else begin
                        nib   = nib - 4'd1;
                        carry = 1'b0;
                     end
                  end
               end
               cnt_d[4*i +: 4] = nib;
            end
         end
      end
   end

   always_comb begin
      scan_d    = scan_q + 1'b1;
      idx_d     = idx_q;
      digit_sel = '0;
      if (scan_q == SCAN_LAST) begin
         scan_d = '0;
         idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) digit_sel = cnt_q[4*i +: 4];
      end
      // an and seg both come from idx_q so the bus never shows a neighbour's digit.
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = decode(digit_sel);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         div_q  <= '0;
         scan_q <= '0;
         idx_q  <= '0;
         cnt_q  <= '0;
         an_q   <= '1;
         seg_q  <= SEG_BLANK;
      end else begin
         div_q  <= div_d;
         scan_q <= scan_d;
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign Count = cnt_q;
   assign an    = an_q;
   assign seg   = seg_q;

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Bench for the 2-digit configuration: directed scenarios plus random traffic,
// checked every cycle against a decimal-arithmetic reference model.
module tb_multi_digit_counter_display;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       En = 1'b0;
   logic       Dir = 1'b0;
   logic       Load = 1'b0;
   logic [7:0] LoadVal = '0;
   logic [7:0] Count;
   logic       Tick;
   logic       Wrap;
   logic [6:0] seg;
   logic [1:0] an;

   int vectors = 0;
   int miscompares = 0;
   int wraps_seen = 0;

   // Reference state: count held as a plain decimal number 0..99.
   bit         m_valid = 1'b0;
   int         m_cnt, m_div, m_scan, m_idx;
   logic [1:0] m_an;
   logic [6:0] m_seg;
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   multi_digit_counter_display #(
      .NUM_DIGITS(2), .TICK_DIV(4), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1)
   ) dut (
      .Clk(Clk), .Rst(Rst), .En(En), .Dir(Dir), .Load(Load), .LoadVal(LoadVal),
      .Count(Count), .Tick(Tick), .Wrap(Wrap), .seg(seg), .an(an)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   // Inputs are already driven; check combinational pulses, advance model, check registers.
   task automatic step();
      bit tick, wrap;
      int lo, hi;
      #1;
      tick = m_valid && En && (m_div == 3);
      if (m_valid) begin
         wrap = tick && !Load && (Dir ? (m_cnt == 0) : (m_cnt == 99));
         chk("tick", {31'd0, Tick}, {31'd0, tick});
         chk("wrap", {31'd0, Wrap}, {31'd0, wrap});
         if (Wrap === 1'b1) wraps_seen++;
      end
      if (Rst) begin
         m_cnt = 0; m_div = 0; m_scan = 0; m_idx = 0;
         m_an = 2'b11; m_seg = 7'h7F; m_valid = 1'b1;
      end else begin
         m_an  = (m_idx == 0) ? 2'b10 : 2'b01;
         m_seg = seg_tab[(m_idx == 0) ? (m_cnt % 10) : (m_cnt / 10)];
         if (m_scan == 2) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % 2;
         end else m_scan++;
         if (Load) begin
            lo = int'(LoadVal[3:0]);
            hi = int'(LoadVal[7:4]);
            if (lo > 9) lo = 0;
            if (hi > 9) hi = 0;
            m_cnt = hi * 10 + lo;
            m_div = 0;
         end else if (tick) begin
            m_cnt = Dir ? (m_cnt + 99) % 100 : (m_cnt + 1) % 100;
            m_div = 0;
         end else if (En) m_div++;
      end
      @(posedge Clk);
      #1;
      if (m_valid) begin
         chk("count", {24'd0, Count}, {24'd0, to_bcd(m_cnt)});
         chk("an", {30'd0, an}, {30'd0, m_an});
         chk("seg", {25'd0, seg}, {25'd0, m_seg});
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input logic [7:0] v);
      Load = 1'b1; LoadVal = v;
      step();
      Load = 1'b0;
   endtask

   initial begin
      // Reset, then idle scan with En low
      Rst = 1'b1; step();
      chk("rst_an", {30'd0, an}, 32'h3);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      Rst = 1'b0;
      run(12);

      // Up count from reset through 100 ticks: exactly one wrap
      Rst = 1'b1; step(); Rst = 1'b0;
      En = 1'b1; Dir = 1'b0;
      wraps_seen = 0;
      run(400);
      chk("wrap_count_up", wraps_seen, 32'd1);
      chk("count_after_100", {24'd0, Count}, 32'h00);

      // Borrow from 10 and wrap below 00
      do_load(8'h10);
      Dir = 1'b1;
      run(8);
      chk("borrow", {24'd0, Count}, 32'h08);
      do_load(8'h00);
      wraps_seen = 0;
      run(4);
      chk("down_wrap", {24'd0, Count}, 32'h99);
      chk("wrap_count_down", wraps_seen, 32'd1);

      // Load coincident with tick, invalid low nibble
      Dir = 1'b0;
      for (int i = 0; i < 8 && m_div != 3; i++) step();
      do_load(8'h5C);
      chk("load_prio", {24'd0, Count}, 32'h50);
      run(4);
      chk("tick_after_load", {24'd0, Count}, 32'h51);

      // En gating with divider parked at 2
      for (int i = 0; i < 8 && m_div != 2; i++) step();
      En = 1'b0;
      run(10);
      En = 1'b1;
      run(3);

      // Reset while digit 1 is displayed and Load is asserted
      En = 1'b0;
      do_load(8'h47);
      for (int i = 0; i < 8 && m_an != 2'b01; i++) step();
      chk("pre_rst_count", {24'd0, Count}, 32'h47);
      chk("pre_rst_an", {30'd0, an}, 32'h1);
      Rst = 1'b1; Load = 1'b1; LoadVal = 8'h99; En = 1'b1;
      step();
      chk("mid_rst_count", {24'd0, Count}, 32'h00);
      chk("mid_rst_an", {30'd0, an}, 32'h3);
      chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
      Rst = 1'b0; Load = 1'b0;

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         Rst     = ($urandom_range(0, 99) == 0);
         En      = ($urandom_range(0, 9) != 0);
         Load    = ($urandom_range(0, 19) == 0);
         LoadVal = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) Dir = ~Dir;
         step();
      end
      Rst = 1'b0; Load = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
